// File: rtl/csr_spmv_pkg.sv
// Shared constants and FSM encoding for the CSR sparse-matrix x dense-vector engine.
package csr_spmv_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANES  = 2;
  localparam int DEF_ROW_AW = 10;
  localparam int DEF_NNZ_AW = 14;
  localparam int DEF_COL_AW = 10;

  // Cycles needed after the last MAC issue for the val/col and vec reads to land.
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR0,
    S_PTR,
    S_MAC,
    S_DRAIN,
    S_EMIT,
    S_FIN
  } state_t;

endpackage

// File: rtl/csr_mac_lane.sv
// One lane: full-width signed multiply of value x vector element into a wrapping accumulator.
module csr_mac_lane #(
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic signed [DATA_W-1:0]   i_val,
  input  logic signed [DATA_W-1:0]   i_vec,
  output logic signed [2*DATA_W-1:0] o_acc
);

  logic signed [2*DATA_W-1:0] w_val_x;
  logic signed [2*DATA_W-1:0] w_vec_x;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] r_acc;

  // Sign-extend first so the low 2*DATA_W bits of the product are exact.
  assign w_val_x = {{DATA_W{i_val[DATA_W-1]}}, i_val};
  assign w_vec_x = {{DATA_W{i_vec[DATA_W-1]}}, i_vec};
  assign w_prod  = w_val_x * w_vec_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/csr_spmv_lanes.sv
// CSR SpMV engine: walks rows of a CSR matrix and multiplies them against LANES dense vectors.
module csr_spmv_lanes
  import csr_spmv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int ROW_AW = DEF_ROW_AW,
  parameter int NNZ_AW = DEF_NNZ_AW,
  parameter int COL_AW = DEF_COL_AW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROW_AW-1:0]           num_rows,
  output logic [ROW_AW-1:0]           rowptr_addr,
  input  logic [31:0]                 rowptr_data,
  output logic [NNZ_AW-1:0]           nnz_addr,
  input  logic [DATA_W-1:0]           val_data,
  input  logic [31:0]                 col_data,
  output logic [COL_AW-1:0]           vec_addr,
  input  logic [LANES*DATA_W-1:0]     vec_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROW_AW-1:0]           out_row,
  output logic [LANES*2*DATA_W-1:0]   out_data,
  output logic                        out_zero,
  output logic                        busy,
  output logic                        done,
  output state_t                      dbg_state
);

  localparam logic [ROW_AW-1:0] ROW_ONE    = ROW_AW'(1);
  localparam logic [NNZ_AW-1:0] NNZ_ONE    = NNZ_AW'(1);
  localparam logic [1:0]        DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ROW_AW-1:0]   r_num_rows;
  logic [ROW_AW-1:0]   r_row;
  logic [NNZ_AW-1:0]   r_nnz_ptr;
  logic [NNZ_AW-1:0]   r_row_end;
  logic                r_zero;
  logic [1:0]          r_drain_cnt;
  logic                r_s1;
  logic                r_s2;
  logic [DATA_W-1:0]   r_val;

  logic [NNZ_AW-1:0]   w_rowptr_nnz;
  logic [NNZ_AW-1:0]   w_nnz_inc;
  logic                w_ptr_lt;
  logic                w_last_row;
  logic                w_clr;
  logic                w_unused;

  assign w_rowptr_nnz = rowptr_data[NNZ_AW-1:0];
  assign w_nnz_inc    = r_nnz_ptr + NNZ_ONE;
  // A start pointer at or past the end pointer (including malformed rows) means an empty row.
  assign w_ptr_lt     = r_nnz_ptr < w_rowptr_nnz;
  assign w_last_row   = r_row == (r_num_rows - ROW_ONE);
  assign w_clr        = r_state == S_PTR;
  assign w_unused     = ^{rowptr_data[31:NNZ_AW], col_data[31:COL_AW]};

  always_comb begin
    w_next      = r_state;
    rowptr_addr = '0;
    case (r_state)
      S_IDLE:  if (start) w_next = (num_rows != '0) ? S_PTR0 : S_FIN;
      S_PTR0: begin
        rowptr_addr = r_row + ROW_ONE;
        w_next      = S_PTR;
      end
      S_PTR:   w_next = w_ptr_lt ? S_MAC : S_EMIT;
      S_MAC:   if (w_nnz_inc == r_row_end) w_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_next = S_EMIT;
      S_EMIT: begin
        // Prefetch the next row's end pointer while waiting for the consumer.
        rowptr_addr = r_row + ROW_ONE + ROW_ONE;
        if (out_ready) w_next = w_last_row ? S_FIN : S_PTR;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num_rows  <= '0;
      r_row       <= '0;
      r_nnz_ptr   <= '0;
      r_row_end   <= '0;
      r_zero      <= 1'b0;
      r_drain_cnt <= '0;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_val       <= '0;
    end else begin
      r_state <= w_next;
      r_s1    <= r_state == S_MAC;
      r_s2    <= r_s1;
      r_val   <= val_data;
      case (r_state)
        S_IDLE: if (start && num_rows != '0) begin
          r_num_rows <= num_rows;
          r_row      <= '0;
        end
        S_PTR0: r_nnz_ptr <= w_rowptr_nnz;
        S_PTR: begin
          r_row_end <= w_rowptr_nnz;
          r_zero    <= !w_ptr_lt;
        end
        S_MAC:   r_nnz_ptr <= w_nnz_inc;
        S_DRAIN: r_drain_cnt <= (r_drain_cnt == DRAIN_LAST) ? 2'd0 : r_drain_cnt + 2'd1;
        S_EMIT:  if (out_ready && !w_last_row) r_row <= r_row + ROW_ONE;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    csr_mac_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (r_s2),
      .i_val (r_val),
      .i_vec (vec_data[g*DATA_W +: DATA_W]),
      .o_acc (out_data[g*2*DATA_W +: 2*DATA_W])
    );
  end

  // out_valid/out_ready: a row transfers on a cycle where both are high; while out_valid is
  // high and out_ready is low, out_row/out_data/out_zero hold and out_valid stays asserted.
  assign out_valid = r_state == S_EMIT;
  assign out_row   = r_row;
  assign out_zero  = r_zero;
  assign nnz_addr  = r_nnz_ptr;
  assign vec_addr  = col_data[COL_AW-1:0];
  assign busy      = r_state != S_IDLE;
  assign done      = r_state == S_FIN;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_csr_spmv_lanes.sv
// Self-checking bench for csr_spmv_lanes: behavioural CSR model, per-cycle output compare.
module tb_csr_spmv_lanes;
  import csr_spmv_pkg::*;

  localparam int DW    = 32;
  localparam int LN    = 2;
  localparam int RAW   = 10;
  localparam int NAW   = 14;
  localparam int CAW   = 10;
  localparam int ACC_W = 2 * DW;
  localparam int EXP_W = RAW + 1 + LN * ACC_W;
  localparam int CHK_W = 160;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [RAW-1:0]       num_rows = '0;
  logic [RAW-1:0]       rowptr_addr;
  logic [31:0]          rowptr_data = '0;
  logic [NAW-1:0]       nnz_addr;
  logic [DW-1:0]        val_data = '0;
  logic [31:0]          col_data = '0;
  logic [CAW-1:0]       vec_addr;
  logic [LN*DW-1:0]     vec_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [RAW-1:0]       out_row;
  logic [LN*ACC_W-1:0]  out_data;
  logic                 out_zero;
  logic                 busy;
  logic                 done;
  state_t               dbg_state;

  always #5 clk = ~clk;

  csr_spmv_lanes dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .rowptr_addr(rowptr_addr), .rowptr_data(rowptr_data),
    .nnz_addr(nnz_addr), .val_data(val_data), .col_data(col_data),
    .vec_addr(vec_addr), .vec_data(vec_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .out_zero(out_zero), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- memories (1-cycle read latency) ----------------
  logic [31:0]   rowptr_mem [0:63];
  logic [DW-1:0] val_mem    [0:255];
  logic [31:0]   col_mem    [0:255];
  logic [DW-1:0] vec_mem    [0:LN-1][0:1023];

  always @(posedge clk) begin
    rowptr_data <= rowptr_mem[rowptr_addr[5:0]];
    val_data    <= val_mem[nnz_addr[7:0]];
    col_data    <= col_mem[nnz_addr[7:0]];
    for (int l = 0; l < LN; l++) vec_data[l*DW +: DW] <= vec_mem[l][vec_addr];
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int ready_mode = 1;  // 0 random, 1 always ready, 2 held low

  task automatic chk(input string name, input logic [CHK_W-1:0] act, input logic [CHK_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic logic [EXP_W-1:0] pack_exp(input logic [RAW-1:0] row, input logic zero,
                                                input logic [ACC_W-1:0] a1, input logic [ACC_W-1:0] a0);
    return {row, zero, a1, a0};
  endfunction

  // Row r covers nonzeros [rowptr[r], rowptr[r+1]); an end at or below the start is an empty row.
  task automatic build_expected(input int nrows);
    longint acc [LN];
    int s, e;
    for (int r = 0; r < nrows; r++) begin
      s = int'(rowptr_mem[r]);
      e = int'(rowptr_mem[r+1]);
      for (int l = 0; l < LN; l++) acc[l] = 0;
      for (int k = s; k < e; k++)
        for (int l = 0; l < LN; l++)
          acc[l] += longint'($signed(val_mem[k])) * longint'($signed(vec_mem[l][col_mem[k][CAW-1:0]]));
      exp_q.push_back(pack_exp(RAW'(r), (e <= s), acc[1], acc[0]));
    end
  endtask

  // Compare process: every accepted row against the model, every stalled cycle for stability.
  logic             prev_valid = 1'b0;
  logic             prev_hs = 1'b0;
  logic [EXP_W-1:0] prev_tuple = '0;
  logic [EXP_W-1:0] e_row;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs)
        chk("hold_stable", {out_valid, out_row, out_zero, out_data}, {1'b1, prev_tuple});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_row: got row %0d, required no output", out_row);
        end else begin
          e_row = exp_q.pop_front();
          chk("row_result", {out_row, out_zero, out_data}, e_row);
        end
      end
      if (done) n_done++;
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_tuple = {out_row, out_zero, out_data};
    end
  end

  // ---------------- drivers ----------------
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic pulse_start(input int nr);
    @(posedge clk); #1;
    start = 1'b1;
    num_rows = RAW'(nr);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) rowptr_mem[i] = '0;
    for (int i = 0; i < 256; i++) begin val_mem[i] = '0; col_mem[i] = '0; end
    for (int l = 0; l < LN; l++) for (int i = 0; i < 1024; i++) vec_mem[l][i] = '0;
  endtask

  task automatic load_small(input int p0, input int p1, input int p2, input int p3);
    clear_mem();
    rowptr_mem[0] = p0; rowptr_mem[1] = p1; rowptr_mem[2] = p2; rowptr_mem[3] = p3;
    val_mem[0] = 2; val_mem[1] = 3; val_mem[2] = 5;
    col_mem[0] = 0; col_mem[1] = 1; col_mem[2] = 2;
    for (int i = 0; i < 3; i++) begin vec_mem[0][i] = i + 1; vec_mem[1][i] = i + 4; end
  endtask

  task automatic gen_random(output int nrows);
    nrows = $urandom_range(1, 8);
    rowptr_mem[0] = $urandom_range(0, 5);
    for (int r = 0; r < nrows; r++) rowptr_mem[r+1] = rowptr_mem[r] + $urandom_range(0, 5);
    for (int k = 0; k < 256; k++) begin val_mem[k] = $urandom; col_mem[k] = $urandom; end
    for (int l = 0; l < LN; l++) for (int i = 0; i < 1024; i++) vec_mem[l][i] = $urandom;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && n_done == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_once", n_done - d0, 1);
    chk("rows_left", exp_q.size(), 0);
  endtask

  // Expected rows must already be queued; optionally poke start while busy.
  task automatic run_op(input int nrows, input bit poke_busy);
    int d0;
    d0 = n_done;
    pulse_start(nrows);
    if (poke_busy) pulse_start(7);
    wait_done(d0, 3000);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int d0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_outputs", {out_valid, done, busy, out_zero, out_row, out_data}, '0);
    chk("rst_addrs", {rowptr_addr, nnz_addr}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {busy, done, out_valid}, '0);

    // Identity 3x3 with vectors [1,2,3] and [4,5,6].
    clear_mem();
    for (int i = 0; i < 4; i++) rowptr_mem[i] = i;
    for (int i = 0; i < 3; i++) begin
      val_mem[i] = 1; col_mem[i] = i; vec_mem[0][i] = i + 1; vec_mem[1][i] = i + 4;
    end
    build_expected(3);
    chk("model_id_r0", exp_q[0], pack_exp(0, 0, 4, 1));
    chk("model_id_r1", exp_q[1], pack_exp(1, 0, 5, 2));
    chk("model_id_r2", exp_q[2], pack_exp(2, 0, 6, 3));
    run_op(3, 0);

    // Empty middle row.
    load_small(0, 2, 2, 3);
    build_expected(3);
    chk("model_empty_r0", exp_q[0], pack_exp(0, 0, 23, 8));
    chk("model_empty_r1", exp_q[1], pack_exp(1, 1, 0, 0));
    chk("model_empty_r2", exp_q[2], pack_exp(2, 0, 30, 15));
    run_op(3, 0);

    // Malformed last row (end pointer below start).
    load_small(0, 2, 3, 1);
    build_expected(3);
    chk("model_malformed_r2", exp_q[2], pack_exp(2, 1, 0, 0));
    run_op(3, 0);

    // Stall row 0 for 10 cycles.
    load_small(0, 2, 2, 3);
    build_expected(3);
    ready_mode = 2;
    d0 = n_done;
    pulse_start(3);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    chk("stall_valid_seen", out_valid, 1);
    repeat (10) @(negedge clk);
    chk("stall_still_valid", {out_valid, out_row}, {1'b1, RAW'(0)});
    ready_mode = 1;
    wait_done(d0, 200);

    // Wrap: four (-2^31)*(-2^31) products sum to 2^64 == 0; lane 1 uses vec=3.
    clear_mem();
    rowptr_mem[0] = 0; rowptr_mem[1] = 4;
    for (int i = 0; i < 4; i++) begin
      val_mem[i] = 32'h8000_0000; col_mem[i] = i; vec_mem[0][i] = 32'h8000_0000; vec_mem[1][i] = 3;
    end
    build_expected(1);
    chk("model_wrap", exp_q[0], pack_exp(0, 0, 64'hFFFF_FFFA_0000_0000, 64'h0));
    run_op(1, 0);

    // Reset in the middle of a long row, then a fresh operation.
    gen_random(n);
    rowptr_mem[0] = 0; rowptr_mem[1] = 20; rowptr_mem[2] = 22;
    pulse_start(2);
    repeat (4) @(posedge clk);
    #1;
    chk("in_mac_before_rst", dbg_state, S_MAC);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {out_valid, done, busy, out_data, nnz_addr}, '0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    gen_random(n);
    build_expected(n);
    run_op(n, 0);

    // Zero rows: straight to FIN, one done pulse, no rows.
    pulse_start(0);
    @(negedge clk);
    chk("zero_rows_fin", {done, busy, out_valid}, 3'b110);
    @(negedge clk);
    chk("zero_rows_idle", {done, busy, out_valid}, 3'b000);

    // Randomized matrices, random back-pressure, some with a start while busy.
    for (int t = 0; t < 8; t++) begin
      gen_random(n);
      build_expected(n);
      ready_mode = (t % 2 == 0) ? 0 : 1;
      run_op(n, (t % 3) == 1);
    end
    ready_mode = 1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
